fir_decim_fifo: RTL and testbench

Output stage placed directly downstream of the pipelined FIR filter. It regenerates a valid flag aligned with the filter's fixed-latency output, and decimates the filtered stream by a programmable integer factor. Kept samples are buffered in a small FIFO behind a valid/ready handshake, so a stalling consumer never back-pressures the free-running filter. Samples that arrive while the FIFO is full are dropped and flagged.

---
 rtl/fir_decim_fifo.sv | 109 ++++++++++
 tb/tb_fir_decim_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: realigns the FIR output valid, decimates the
// stream and buffers kept samples behind a valid/ready handshake.
module fir_decim_fifo #(
  parameter int WW_DATA    = 8,
  parameter int PIPE_LAT   = 3,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          i_srst_n,
  input  logic                          i_en,
  input  logic [WW_DATA-1:0]            i_data,
  output logic [WW_DATA-1:0]            o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   LV_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_P   = (AW+1)'(1);

  logic [PIPE_LAT-1:0] vline;
  logic                v_aligned;
  logic [PW-1:0]       phase;
  logic                keep;
  logic                pop;
  logic                full;
  logic                wr;
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic [AW:0]         rptr_n;
  logic [AW:0]         level_n;
  logic                head_byp;
  logic [WW_DATA-1:0]  mem [FIFO_DEPTH];

  // valid delay line: free-running copy of the filter latency
  generate
    if (PIPE_LAT == 1) begin : g_v1
      always_ff @(posedge clk) begin
        if (!i_srst_n) vline <= '0;
        else           vline <= i_en;
      end
    end else begin : g_vn
      always_ff @(posedge clk) begin
        if (!i_srst_n) vline <= '0;
        else           vline <= {vline[PIPE_LAT-2:0], i_en};
      end
    end
  endgenerate

  assign v_aligned = vline[PIPE_LAT-1];

  // decimation phase, advancing only on real filter outputs
  always_ff @(posedge clk) begin
    if (!i_srst_n) begin
      phase <= '0;
    end else if (v_aligned) begin
      if (phase == PH_LAST) phase <= '0;
      else                  phase <= phase + PW'(1);
    end
  end

  // push/pop decisions and next-state of the read side
  always_comb begin
    pop      = o_valid & i_ready;
    full     = (o_level == LV_FULL);
    keep     = v_aligned & (phase == '0);
    wr       = keep & (~full | pop);
    rptr_n   = pop ? (rptr + ONE_P) : rptr;
    head_byp = wr & (rptr_n == wptr);
    level_n  = o_level;
    case ({wr, pop})
      2'b10:   level_n = o_level + ONE_P;
      2'b01:   level_n = o_level - ONE_P;
      default: level_n = o_level;
    endcase
  end

  // storage array; contents need no reset, pointers gate them
  always_ff @(posedge clk) begin
    if (i_srst_n && wr) mem[wptr[AW-1:0]] <= i_data;
  end

  // pointers, occupancy, registered head and sticky overflow
  always_ff @(posedge clk) begin
    if (!i_srst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      o_level    <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
      o_data     <= '0;
    end else begin
      if (wr) wptr <= wptr + ONE_P;
      rptr    <= rptr_n;
      o_level <= level_n;
      o_valid <= (level_n != '0);
      if (keep & full & ~pop) o_overflow <= 1'b1;
      if (head_byp)  o_data <= i_data;
      else if (pop)  o_data <= mem[rptr_n[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// tb_fir_decim_fifo: vectors, corner sequences and random traffic
// on three decimation factors against a queue-based model.
module tb_fir_decim_fifo;

  localparam int PL    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic       ready;
  logic [7:0] data;

  logic [7:0] od [3];
  logic       ov [3];
  logic [3:0] ol [3];
  logic       of [3];

  fir_decim_fifo #(.WW_DATA(8), .PIPE_LAT(PL), .DECIM(1),
                   .FIFO_DEPTH(DEPTH)) u_d1 (
    .clk(clk), .i_srst_n(rst_n), .i_en(en), .i_data(data),
    .o_data(od[0]), .o_valid(ov[0]), .i_ready(ready),
    .o_level(ol[0]), .o_overflow(of[0]));

  fir_decim_fifo #(.WW_DATA(8), .PIPE_LAT(PL), .DECIM(2),
                   .FIFO_DEPTH(DEPTH)) u_d2 (
    .clk(clk), .i_srst_n(rst_n), .i_en(en), .i_data(data),
    .o_data(od[1]), .o_valid(ov[1]), .i_ready(ready),
    .o_level(ol[1]), .o_overflow(of[1]));

  fir_decim_fifo #(.WW_DATA(8), .PIPE_LAT(PL), .DECIM(4),
                   .FIFO_DEPTH(DEPTH)) u_d4 (
    .clk(clk), .i_srst_n(rst_n), .i_en(en), .i_data(data),
    .o_data(od[2]), .o_valid(ov[2]), .i_ready(ready),
    .o_level(ol[2]), .o_overflow(of[2]));

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [3][$];
  bit         mof [3];
  int         acnt [3];
  bit         ehist [$];
  int         dec [3] = '{1, 2, 4};

  typedef struct {
    bit         r;
    bit         e;
    logic [7:0] d;
    bit         rd;
    bit         xv;
    int         xl;
    bit         xo;
    logic [7:0] xd;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic add(input bit r, input bit e, input logic [7:0] d,
                     input bit rd, input bit xv, input int xl,
                     input bit xo, input logic [7:0] xd);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.rd = rd;
    v.xv = xv; v.xl = xl; v.xo = xo; v.xd = xd;
    tv.push_back(v);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      ehist.delete();
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        mof[i]  = 1'b0;
        acnt[i] = 0;
      end
    end else begin
      bit al;
      al = (ehist.size() >= PL) ? ehist[ehist.size() - PL] : 1'b0;
      for (int i = 0; i < 3; i++) begin
        bit full;
        bit pop;
        bit keep;
        full = (mq[i].size() == DEPTH);
        pop  = (mq[i].size() > 0) && ready;
        keep = al && ((acnt[i] % dec[i]) == 0);
        if (al) acnt[i]++;
        if (pop) void'(mq[i].pop_front());
        if (keep) begin
          if (!full || pop) mq[i].push_back(data);
          else              mof[i] = 1'b1;
        end
      end
      ehist.push_back(en);
      if (ehist.size() > PL) void'(ehist.pop_front());
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      int n;
      n = mq[i].size();
      chk($sformatf("m%0d.valid", i), int'(ov[i]), int'(n > 0));
      chk($sformatf("m%0d.level", i), int'(ol[i]), n);
      chk($sformatf("m%0d.ovf", i), int'(of[i]), int'(mof[i]));
      if (n > 0)
        chk($sformatf("m%0d.data", i), int'(od[i]), int'(mq[i][0]));
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] d,
                      input bit rd);
    rst_n = r; en = e; data = d; ready = rd;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  logic [7:0] seen [$];
  logic [7:0] last;
  bit         lo_phase;

  initial begin
    rst_n = 1'b0; en = 1'b0; data = '0; ready = 1'b0;

    // reset held with enable active
    for (int k = 0; k < 3; k++) add(0, 1, 8'h00, 1, 0, 0, 0, 8'h00);
    // single pass-through sample, DECIM=1
    add(1, 1, 8'h00, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h35, 1, 1, 1, 0, 8'h35);
    add(1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    // fill past full with consumer stalled
    for (int k = 0; k <= 12; k++) begin
      int lv;
      lv = (k < 3) ? 0 : ((k - 2 > 8) ? 8 : k - 2);
      add(1, k < 10, (k >= 3) ? 8'(8'h10 + k - 3) : 8'h00, 0,
          lv > 0, lv, k >= 11, 8'h10);
    end
    // drain in order
    for (int j = 0; j <= 8; j++) begin
      int lv;
      lv = (j <= 7) ? 7 - j : 0;
      add(1, 0, 8'h00, 1, lv > 0, lv, 1, 8'(8'h11 + j));
    end

    foreach (tv[n]) begin
      rst_n = tv[n].r; en = tv[n].e; data = tv[n].d; ready = tv[n].rd;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      chk($sformatf("v%0d.valid", n), int'(ov[0]), int'(tv[n].xv));
      chk($sformatf("v%0d.level", n), int'(ol[0]), tv[n].xl);
      chk($sformatf("v%0d.ovf", n), int'(of[0]), int'(tv[n].xo));
      if (tv[n].xv || !tv[n].r)
        chk($sformatf("v%0d.data", n), int'(od[0]), int'(tv[n].xd));
      if (!tv[n].r)
        for (int i = 1; i < 3; i++)
          chk($sformatf("v%0d.rdata%0d", n, i), int'(od[i]), 0);
    end

    // DECIM=4 on a continuous ramp
    step(0, 0, 8'h00, 1);
    seen.delete();
    for (int k = 0; k <= 18; k++) begin
      step(1, 1, (k >= 3) ? 8'(k - 3) : 8'h00, 1);
      if (ov[2]) seen.push_back(od[2]);
    end
    chk("dec4.count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk($sformatf("dec4.out%0d", i), int'(seen[i]), 4 * i);

    // DECIM=2 with enable every third clock
    step(0, 0, 8'h00, 1);
    seen.delete();
    for (int k = 0; k <= 20; k++) begin
      bit al;
      al = (k >= 3) && (k % 3 == 0);
      step(1, (k % 3 == 0) && (k <= 15),
           al ? 8'(k / 3 - 1) : 8'hAA, 1);
      if (ov[1]) seen.push_back(od[1]);
    end
    chk("gap.count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      chk($sformatf("gap.out%0d", i), int'(seen[i]), 2 * i);

    // full FIFO with a simultaneous pop and push
    step(0, 0, 8'h00, 0);
    for (int k = 0; k <= 11; k++)
      step(1, k < 9,
           (k == 11) ? 8'h7F : ((k >= 3) ? 8'(8'h10 + k - 3) : 8'h00),
           k == 11);
    chk("fp.level", int'(ol[0]), 8);
    chk("fp.ovf", int'(of[0]), 0);
    last = od[0];
    for (int k = 0; k < 10; k++) begin
      if (ov[0]) last = od[0];
      step(1, 0, 8'h00, 1);
    end
    chk("fp.last", int'(last), 8'h7F);
    chk("fp.empty", int'(ol[0]), 0);

    // overflow then a one-clock reset pulse
    for (int k = 0; k <= 12; k++)
      step(1, k < 10, 8'($urandom), 0);
    chk("rs.ovf_set", int'(of[0]), 1);
    step(0, 1, 8'h00, 0);
    chk("rs.level", int'(ol[0]), 0);
    chk("rs.valid", int'(ov[0]), 0);
    chk("rs.ovf", int'(of[0]), 0);
    step(1, 0, 8'h00, 0);
    chk("rs.ovf_hold", int'(of[0]), 0);

    // random traffic, alternating eager and reluctant consumer
    step(0, 0, 8'h00, 0);
    for (int c = 0; c < 3000; c++) begin
      lo_phase = ((c / 200) % 2) == 1;
      step($urandom_range(0, 99) != 0,
           1'($urandom % 2),
           8'($urandom),
           lo_phase ? ($urandom_range(0, 3) == 0)
                    : ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
